// File: rtl/vga_output_stage_pkg.sv
// Shared definitions for the VGA output stage: dither modes, the 4x4 Bayer
// matrix and the helper that scales a matrix entry to the dropped-bit range.
package vga_output_stage_pkg;

    typedef enum logic [1:0] {
        TRUNC    = 2'd0,
        BAYER    = 2'd1,
        TEMPORAL = 2'd2
    } mode_e;

    // Width of the scaled threshold; IN_W must not exceed this.
    localparam int THR_W = 16;

    // Indexed as BAYER4[yi][xi].
    localparam logic [3:0] BAYER4 [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6 },
        '{4'd3,  4'd11, 4'd1,  4'd9 },
        '{4'd15, 4'd7,  4'd13, 4'd5 }
    };

    // s is the number of bits dropped per channel (IN_W - OUT_W).
    function automatic logic [THR_W-1:0] bayer_thresh(input logic [3:0] b, input int s);
        logic [THR_W-1:0] bw;
        bw = {{(THR_W-4){1'b0}}, b};
        if (s >= 4) begin
            return bw << (s - 4);
        end else if (s > 0) begin
            return bw >> (4 - s);
        end else begin
            return '0;
        end
    endfunction

endpackage

// File: rtl/vga_output_stage_dither_channel.sv
// One colour channel: threshold add with saturation, then truncation and
// blank forcing. Two register stages, matching the sync pipeline in the top.
module vga_dither_channel
    import vga_output_stage_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 4,
    parameter bit DITHER = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IN_W-1:0]  pix_i,
    input  logic [IN_W-1:0]  thr_i,
    input  logic             blank_i,
    output logic [OUT_W-1:0] pix_o
);

    localparam int S = IN_W - OUT_W;

    logic [IN_W:0]    wide;
    logic [IN_W-1:0]  sum_d, sum_q;
    logic             blank_q;
    logic [OUT_W-1:0] out_d, out_q;
    logic             unused_bits;

    assign wide = {1'b0, pix_i} + {1'b0, thr_i};

    always_comb begin
        sum_d = pix_i;
        if (DITHER) begin
            sum_d = wide[IN_W] ? {IN_W{1'b1}} : wide[IN_W-1:0];
        end
    end

    assign out_d = blank_q ? '0 : sum_q[IN_W-1:S];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q   <= '0;
            blank_q <= 1'b0;
            out_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            blank_q <= blank_i;
            out_q   <= out_d;
        end
    end

    assign pix_o = out_q;

    // Low sum bits are dropped by design; thr_i is ignored without dithering.
    assign unused_bits = ^{sum_q, thr_i};

endmodule

// File: rtl/vga_output_stage.sv
// VGA output stage: screen-position tracking from sync strobes, Bayer
// threshold selection, three dither channels and a delay-matched sync pipe.
module vga_output_stage
    import vga_output_stage_pkg::*;
#(
    parameter int IN_W            = 8,
    parameter int OUT_W           = 4,
    parameter int MODE            = 1,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic             CLK_25MHZ,
    input  logic             RESET,
    input  logic [IN_W-1:0]  IN_RED,
    input  logic [IN_W-1:0]  IN_GREEN,
    input  logic [IN_W-1:0]  IN_BLUE,
    input  logic             IN_BLANK,
    input  logic             IN_HSYNC,
    input  logic             IN_VSYNC,
    output logic [OUT_W-1:0] VGA_RED,
    output logic [OUT_W-1:0] VGA_GREEN,
    output logic [OUT_W-1:0] VGA_BLUE,
    output logic             VGA_HSYNC,
    output logic             VGA_VSYNC
);

    localparam int   S         = IN_W - OUT_W;
    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam bit   DITHER    = (MODE != int'(TRUNC)) && (S != 0);
    localparam bit   ROTATE    = (MODE == int'(TEMPORAL));

    logic             hs_act, vs_act, hs_edge, vs_edge;
    logic             hs_prev_q, vs_prev_q;
    logic [1:0]       x_d, x_q, y_d, y_q, f_d, f_q;
    logic [1:0]       xi, yi;
    logic [THR_W-1:0] thr_full;
    logic [IN_W-1:0]  thr;
    logic             hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
    logic             unused_thr;

    assign hs_act  = (IN_HSYNC != SYNC_IDLE);
    assign vs_act  = (IN_VSYNC != SYNC_IDLE);
    assign hs_edge = hs_act & ~hs_prev_q;
    assign vs_edge = vs_act & ~vs_prev_q;

    // A coincident VSYNC edge overrides the line increment.
    always_comb begin
        x_d = x_q + 2'd1;
        y_d = y_q;
        f_d = f_q;
        if (hs_edge) begin
            x_d = 2'd0;
            y_d = y_q + 2'd1;
        end
        if (vs_edge) begin
            y_d = 2'd0;
            f_d = f_q + 2'd1;
        end
    end

    always_comb begin
        xi = x_q;
        yi = y_q;
        if (ROTATE) begin
            xi = x_q + f_q;
            yi = y_q + f_q;
        end
    end

    assign thr_full   = bayer_thresh(BAYER4[yi][xi], S);
    assign thr        = DITHER ? thr_full[IN_W-1:0] : '0;
    assign unused_thr = ^thr_full;

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            x_q       <= 2'd0;
            y_q       <= 2'd0;
            f_q       <= 2'd0;
            hs_s1_q   <= SYNC_IDLE;
            hs_s2_q   <= SYNC_IDLE;
            vs_s1_q   <= SYNC_IDLE;
            vs_s2_q   <= SYNC_IDLE;
        end else begin
            hs_prev_q <= hs_act;
            vs_prev_q <= vs_act;
            x_q       <= x_d;
            y_q       <= y_d;
            f_q       <= f_d;
            hs_s1_q   <= IN_HSYNC;
            hs_s2_q   <= hs_s1_q;
            vs_s1_q   <= IN_VSYNC;
            vs_s2_q   <= vs_s1_q;
        end
    end

    assign VGA_HSYNC = hs_s2_q;
    assign VGA_VSYNC = vs_s2_q;

    vga_dither_channel #(.IN_W(IN_W), .OUT_W(OUT_W), .DITHER(DITHER)) u_red (
        .clk_i(CLK_25MHZ), .rst_i(RESET), .pix_i(IN_RED), .thr_i(thr),
        .blank_i(IN_BLANK), .pix_o(VGA_RED)
    );

    vga_dither_channel #(.IN_W(IN_W), .OUT_W(OUT_W), .DITHER(DITHER)) u_green (
        .clk_i(CLK_25MHZ), .rst_i(RESET), .pix_i(IN_GREEN), .thr_i(thr),
        .blank_i(IN_BLANK), .pix_o(VGA_GREEN)
    );

    vga_dither_channel #(.IN_W(IN_W), .OUT_W(OUT_W), .DITHER(DITHER)) u_blue (
        .clk_i(CLK_25MHZ), .rst_i(RESET), .pix_i(IN_BLUE), .thr_i(thr),
        .blank_i(IN_BLANK), .pix_o(VGA_BLUE)
    );

endmodule
